// File: rtl/record_bank.sv
// Multi-track note recorder: appends {octave, note, length, full_note} entries per track, streams them back.
// Latency: play_start/play_next -> entry outputs and out_valid one cycle later; overflow/play_done pulse one cycle after cause.
// Backpressure: none; rec_valid on a full track is dropped and flagged via overflow, play_next is pulse-driven by the player.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   track_sel                   track addressed by rec_start / play_start / clr
//   rec_start, rec_stop         enter / leave recording
//   rec_valid + entry fields    append one entry while recording
//   play_start, play_next,      enter playback (loop sampled here), advance, abort
//   play_stop, loop
//   clr                         empty track_sel while idle
//   *_r, out_valid              registered playback entry and its qualifier
//   play_done, overflow         one-cycle event pulses
//   busy, cur_track, count,     status (count follows track_sel when idle, cur_track otherwise)
//   full, empty
module record_bank #(
  parameter int TRACKS         = 4,
  parameter int DEPTH_BITS     = 5,
  parameter int OCTAVE_BITS    = 2,
  parameter int NOTE_BITS      = 3,
  parameter int LENGTH_BITS    = 4,
  parameter int FULL_NOTE_BITS = 4,
  localparam int TRK_BITS      = $clog2(TRACKS),
  localparam int CNT_BITS      = DEPTH_BITS + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TRK_BITS-1:0]       track_sel,
  input  logic                      rec_start,
  input  logic                      rec_stop,
  input  logic                      rec_valid,
  input  logic [OCTAVE_BITS-1:0]    octave,
  input  logic [NOTE_BITS-1:0]      note,
  input  logic [LENGTH_BITS-1:0]    length,
  input  logic [FULL_NOTE_BITS-1:0] full_note,
  input  logic                      play_start,
  input  logic                      play_next,
  input  logic                      play_stop,
  input  logic                      loop,
  input  logic                      clr,
  output logic [OCTAVE_BITS-1:0]    octave_r,
  output logic [NOTE_BITS-1:0]      note_r,
  output logic [LENGTH_BITS-1:0]    length_r,
  output logic [FULL_NOTE_BITS-1:0] full_note_r,
  output logic                      out_valid,
  output logic                      play_done,
  output logic                      overflow,
  output logic                      busy,
  output logic [TRK_BITS-1:0]       cur_track,
  output logic [CNT_BITS-1:0]       count,
  output logic                      full,
  output logic                      empty
);

  localparam int DEPTH     = 1 << DEPTH_BITS;
  localparam int ADDR_BITS = TRK_BITS + DEPTH_BITS;
  localparam logic [CNT_BITS-1:0]   CNT_FULL = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0]   CNT_ONE  = CNT_BITS'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ZERO = '0;

  typedef struct packed {
    logic [OCTAVE_BITS-1:0]    octave;
    logic [NOTE_BITS-1:0]      note;
    logic [LENGTH_BITS-1:0]    length;
    logic [FULL_NOTE_BITS-1:0] full_note;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TRK_BITS-1:0]   cur_track_q, cur_track_d;
  logic                  loop_q, loop_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]   cnt_q [TRACKS];

  // Flat storage addressed {track, index}; intentionally not reset.
  entry_t                mem [TRACKS*DEPTH];

  entry_t                wr_dat;
  logic [ADDR_BITS-1:0]  wr_addr, rd_addr;
  logic                  wr_en, rd_en, cnt_clr;
  logic                  out_valid_d, play_done_d, overflow_d;
  logic [CNT_BITS-1:0]   sel_cnt, cur_cnt;
  logic                  rd_last;

  assign sel_cnt = cnt_q[track_sel];
  assign cur_cnt = cnt_q[cur_track_q];
  // rd_ptr sits on the final stored entry of the current track.
  assign rd_last = (({1'b0, rd_ptr_q} + CNT_ONE) == cur_cnt);
  assign wr_dat  = {octave, note, length, full_note};
  // Appends land at index == current fill count; only used while count < DEPTH.
  assign wr_addr = {cur_track_q, cur_cnt[DEPTH_BITS-1:0]};

  assign busy      = (state_q != IDLE);
  assign cur_track = cur_track_q;
  assign count     = (state_q == IDLE) ? sel_cnt : cur_cnt;
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);

  always_comb begin
    state_d     = state_q;
    cur_track_d = cur_track_q;
    loop_d      = loop_q;
    rd_ptr_d    = rd_ptr_q;
    rd_addr     = {cur_track_q, rd_ptr_q};
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    cnt_clr     = 1'b0;
    out_valid_d = 1'b0;
    play_done_d = 1'b0;
    overflow_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rec_start) begin
          state_d     = REC;
          cur_track_d = track_sel;
        end else if (play_start) begin
          cur_track_d = track_sel;
          loop_d      = loop;
          if (sel_cnt != '0) begin
            state_d     = PLAY;
            rd_ptr_d    = '0;
            rd_addr     = {track_sel, PTR_ZERO};
            rd_en       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            // Nothing to play: report completion straight away.
            play_done_d = 1'b1;
          end
        end else if (clr) begin
          cnt_clr = 1'b1;
        end
      end

      REC: begin
        // A write in the same cycle as rec_stop still completes.
        if (rec_valid) begin
          if (cur_cnt != CNT_FULL) wr_en = 1'b1;
          else                     overflow_d = 1'b1;
        end
        if (rec_stop) state_d = IDLE;
      end

      PLAY: begin
        out_valid_d = 1'b1;
        if (play_stop) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (play_next) begin
          if (!rd_last) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rd_addr  = {cur_track_q, rd_ptr_q + PTR_ONE};
            rd_en    = 1'b1;
          end else if (loop_q) begin
            rd_ptr_d = '0;
            rd_addr  = {cur_track_q, PTR_ZERO};
            rd_en    = 1'b1;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            play_done_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_track_q <= '0;
      loop_q      <= 1'b0;
      rd_ptr_q    <= '0;
      out_valid   <= 1'b0;
      play_done   <= 1'b0;
      overflow    <= 1'b0;
      {octave_r, note_r, length_r, full_note_r} <= '0;
      for (int i = 0; i < TRACKS; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_track_q <= cur_track_d;
      loop_q      <= loop_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid   <= out_valid_d;
      play_done   <= play_done_d;
      overflow    <= overflow_d;
      // Entry outputs double as the read register and hold after playback ends.
      if (rd_en) {octave_r, note_r, length_r, full_note_r} <= mem[rd_addr];
      if (wr_en) cnt_q[cur_track_q] <= cur_cnt + CNT_ONE;
      if (cnt_clr) cnt_q[track_sel] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_addr] <= wr_dat;
  end

endmodule

// File: tb/tb_record_bank.sv
module tb_record_bank;

  localparam int TRACKS = 4;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] track_sel = '0;
  logic       rec_start = 0, rec_stop = 0, rec_valid = 0;
  logic [1:0] octave = '0;
  logic [2:0] note = '0;
  logic [3:0] length = '0;
  logic [3:0] full_note = '0;
  logic       play_start = 0, play_next = 0, play_stop = 0, loop = 0, clr = 0;
  logic [1:0] octave_r;
  logic [2:0] note_r;
  logic [3:0] length_r;
  logic [3:0] full_note_r;
  logic       out_valid, play_done, overflow, busy, full, empty;
  logic [1:0] cur_track;
  logic [2:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: per-track list of stored entries plus fill count.
  logic [12:0] model_mem [TRACKS][DEPTH];
  int          model_cnt [TRACKS];

  wire [12:0] obs_entry = {octave_r, note_r, length_r, full_note_r};

  record_bank #(
    .TRACKS(4), .DEPTH_BITS(2), .OCTAVE_BITS(2), .NOTE_BITS(3), .LENGTH_BITS(4), .FULL_NOTE_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .track_sel(track_sel),
    .rec_start(rec_start), .rec_stop(rec_stop), .rec_valid(rec_valid),
    .octave(octave), .note(note), .length(length), .full_note(full_note),
    .play_start(play_start), .play_next(play_next), .play_stop(play_stop), .loop(loop), .clr(clr),
    .octave_r(octave_r), .note_r(note_r), .length_r(length_r), .full_note_r(full_note_r),
    .out_valid(out_valid), .play_done(play_done), .overflow(overflow), .busy(busy),
    .cur_track(cur_track), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (tests run %0d)", tests_run);
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [12:0] e);
    {octave, note, length, full_note} = e;
  endtask

  task automatic model_append(input int t, input logic [12:0] e);
    if (model_cnt[t] < DEPTH) begin
      model_mem[t][model_cnt[t]] = e;
      model_cnt[t]++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < TRACKS; t++) model_cnt[t] = 0;
    tests_run++;
    if ({busy, out_valid, play_done, overflow} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/ov/pd/of=%b expected 0000", {busy, out_valid, play_done, overflow});
    end
    tests_run++;
    if (obs_entry !== 13'h0 || cur_track !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got entry=%h cur_track=%0d expected 0/0", obs_entry, cur_track);
    end
    for (int t = 0; t < TRACKS; t++) begin
      track_sel = 2'(t);
      #1;
      tests_run++;
      if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_count trk%0d: got count=%0d empty=%b full=%b expected 0/1/0", t, count, empty, full);
      end
    end
  endtask

  task automatic test_append_playback();
    logic [12:0] e;
    track_sel = 2'd1; rec_start = 1; tick(); rec_start = 0;
    tests_run++;
    if (busy !== 1'b1 || cur_track !== 2'd1) begin
      tests_failed++;
      $display("FAIL append_rec_enter: got busy=%b cur_track=%0d expected 1/1", busy, cur_track);
    end
    for (int i = 0; i < 3; i++) begin
      e = 13'($urandom);
      e[10:8] = 3'(i + 1);
      set_entry(e); rec_valid = 1; tick(); rec_valid = 0;
      model_append(1, e);
      tests_run++;
      if (count !== 3'(i + 1)) begin
        tests_failed++;
        $display("FAIL append_count: got %0d expected %0d", count, i + 1);
      end
    end
    rec_stop = 1; tick(); rec_stop = 0;
    tests_run++;
    if (busy !== 1'b0 || count !== 3'd3) begin
      tests_failed++;
      $display("FAIL append_stop: got busy=%b count=%0d expected 0/3", busy, count);
    end
    loop = 0; play_start = 1; tick(); play_start = 0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || note_r !== 3'(i + 1) || obs_entry !== model_mem[1][i]) begin
        tests_failed++;
        $display("FAIL append_play step%0d: got vld=%b note=%0d entry=%h expected 1/%0d/%h",
                 i, out_valid, note_r, obs_entry, i + 1, model_mem[1][i]);
      end
      play_next = 1; tick(); play_next = 0;
    end
    tests_run++;
    if (play_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL append_done: got pd=%b vld=%b busy=%b expected 1/0/0", play_done, out_valid, busy);
    end
    tick();
    tests_run++;
    if (play_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL append_done_pulse: got pd=%b expected 0", play_done);
    end
  endtask

  task automatic test_overflow();
    logic [12:0] e;
    track_sel = 2'd0; rec_start = 1; tick(); rec_start = 0;
    for (int i = 0; i < 5; i++) begin
      e = 13'($urandom);
      set_entry(e); rec_valid = 1; tick(); rec_valid = 0;
      model_append(0, e);
      tests_run++;
      if (overflow !== (i == 4)) begin
        tests_failed++;
        $display("FAIL overflow_pulse write%0d: got %b expected %b", i, overflow, i == 4);
      end
    end
    tests_run++;
    if (count !== 3'd4 || full !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_count: got count=%0d full=%b busy=%b expected 4/1/1", count, full, busy);
    end
    rec_stop = 1; tick(); rec_stop = 0;
    tests_run++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_once: got overflow=%b busy=%b expected 0/0", overflow, busy);
    end
  endtask

  // Plays a whole track without looping and compares every entry with the model.
  task automatic test_playback(input int t);
    track_sel = 2'(t); loop = 0; play_start = 1; tick(); play_start = 0;
    for (int i = 0; i < model_cnt[t]; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || obs_entry !== model_mem[t][i]) begin
        tests_failed++;
        $display("FAIL playback trk%0d idx%0d: got vld=%b entry=%h expected 1/%h",
                 t, i, out_valid, obs_entry, model_mem[t][i]);
      end
      play_next = 1; tick(); play_next = 0;
    end
    tests_run++;
    if (play_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL playback_done trk%0d: got pd=%b vld=%b busy=%b expected 1/0/0", t, play_done, out_valid, busy);
    end
    tick();
    tests_run++;
    if (play_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL playback_done_pulse trk%0d: got pd=%b expected 0", t, play_done);
    end
  endtask

  task automatic test_loop();
    logic [12:0] e;
    track_sel = 2'd2; rec_start = 1; tick(); rec_start = 0;
    for (int i = 0; i < 2; i++) begin
      e = 13'($urandom);
      set_entry(e); rec_valid = 1; tick(); rec_valid = 0;
      model_append(2, e);
    end
    rec_stop = 1; tick(); rec_stop = 0;
    loop = 1; play_start = 1; tick(); play_start = 0; loop = 0;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || play_done !== 1'b0 || obs_entry !== model_mem[2][i % 2]) begin
        tests_failed++;
        $display("FAIL loop step%0d: got vld=%b pd=%b entry=%h expected 1/0/%h",
                 i, out_valid, play_done, obs_entry, model_mem[2][i % 2]);
      end
      if (i < 5) begin
        play_next = 1; tick(); play_next = 0;
      end
    end
    // play_stop must win over a simultaneous play_next (which would otherwise wrap).
    play_stop = 1; play_next = 1; tick(); play_stop = 0; play_next = 0;
    tests_run++;
    if (out_valid !== 1'b0 || play_done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL loop_stop: got vld=%b pd=%b busy=%b expected 0/0/0", out_valid, play_done, busy);
    end
  endtask

  task automatic test_empty_clear();
    track_sel = 2'd3; play_start = 1; tick(); play_start = 0;
    tests_run++;
    if (play_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_play: got pd=%b vld=%b busy=%b expected 1/0/0", play_done, out_valid, busy);
    end
    tick();
    tests_run++;
    if (play_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_play_pulse: got pd=%b expected 0", play_done);
    end
    track_sel = 2'd1; clr = 1; tick(); clr = 0;
    model_cnt[1] = 0;
    tests_run++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_count: got count=%0d empty=%b expected 0/1", count, empty);
    end
    track_sel = 2'd0; #1;
    tests_run++;
    if (count !== 3'(model_cnt[0])) begin
      tests_failed++;
      $display("FAIL clear_other_track: got count=%0d expected %0d", count, model_cnt[0]);
    end
  endtask

  task automatic test_ignored();
    logic [12:0] e;
    track_sel = 2'd3; rec_start = 1; tick(); rec_start = 0;
    e = 13'($urandom);
    set_entry(e); rec_valid = 1; tick(); rec_valid = 0;
    model_append(3, e);
    play_start = 1; clr = 1; tick(); play_start = 0; clr = 0;
    tests_run++;
    if (busy !== 1'b1 || count !== 3'd1 || out_valid !== 1'b0 || play_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_in_rec: got busy=%b count=%0d vld=%b pd=%b expected 1/1/0/0", busy, count, out_valid, play_done);
    end
    track_sel = 2'd1; rec_start = 1; tick(); rec_start = 0;
    tests_run++;
    if (cur_track !== 2'd3) begin
      tests_failed++;
      $display("FAIL ignored_rec_start: got cur_track=%0d expected 3", cur_track);
    end
    e = 13'($urandom);
    set_entry(e); rec_valid = 1; rec_stop = 1; tick(); rec_valid = 0; rec_stop = 0;
    model_append(3, e);
    track_sel = 2'd3; #1;
    tests_run++;
    if (busy !== 1'b0 || count !== 3'd2) begin
      tests_failed++;
      $display("FAIL write_with_stop: got busy=%b count=%0d expected 0/2", busy, count);
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    int t, nw;
    bit exp_ovf;
    for (int n = 0; n < 16; n++) begin
      t = $urandom_range(0, TRACKS - 1);
      track_sel = 2'(t);
      if ($urandom_range(0, 1) == 1) begin
        clr = 1; tick(); clr = 0;
        model_cnt[t] = 0;
      end
      rec_start = 1; tick(); rec_start = 0;
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) begin
        e = 13'($urandom);
        exp_ovf = (model_cnt[t] == DEPTH);
        set_entry(e); rec_valid = 1; tick(); rec_valid = 0;
        model_append(t, e);
        tests_run++;
        if (overflow !== exp_ovf) begin
          tests_failed++;
          $display("FAIL random_overflow trk%0d: got %b expected %b", t, overflow, exp_ovf);
        end
      end
      rec_stop = 1; tick(); rec_stop = 0;
      tests_run++;
      if (count !== 3'(model_cnt[t])) begin
        tests_failed++;
        $display("FAIL random_count trk%0d: got %0d expected %0d", t, count, model_cnt[t]);
      end
      test_playback(t);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    track_sel = 2'd2; clr = 1; tick(); clr = 0;
    rec_start = 1; tick(); rec_start = 0;
    e = 13'($urandom);
    set_entry(e); rec_valid = 1; tick(); rec_valid = 0;
    rec_stop = 1; tick(); rec_stop = 0;
    play_start = 1; tick(); play_start = 0;
    tests_run++;
    if (out_valid !== 1'b1 || obs_entry !== e) begin
      tests_failed++;
      $display("FAIL reset_mid_play: got vld=%b entry=%h expected 1/%h", out_valid, obs_entry, e);
    end
    rst_n = 0; tick(); rst_n = 1;
    for (int t = 0; t < TRACKS; t++) model_cnt[t] = 0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || play_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_state: got vld=%b busy=%b pd=%b expected 0/0/0", out_valid, busy, play_done);
    end
    for (int t = 0; t < TRACKS; t++) begin
      track_sel = 2'(t); #1;
      tests_run++;
      if (count !== 3'd0) begin
        tests_failed++;
        $display("FAIL reset_mid_count trk%0d: got %0d expected 0", t, count);
      end
    end
    track_sel = 2'd2; play_start = 1; tick(); play_start = 0;
    tests_run++;
    if (play_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_replay: got pd=%b vld=%b busy=%b expected 1/0/0", play_done, out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_append_playback();
    test_overflow();
    test_playback(0);
    test_loop();
    test_empty_clear();
    test_playback(0);
    test_ignored();
    test_playback(3);
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
